// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: one-entry valid/ready stage holding the decoded bundle,
// with branch flush, a one-bubble load-use interlock and stall/bubble counters.
module id_ex_pipe_reg #(
  parameter int W    = 220,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  input  logic            flush,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] bubble_cnt
);

  localparam int INST_LO  = 188;
  localparam int MEM_RD   = 94;
  localparam int WR_RT    = 75;

  logic [4:0] in_rs, in_rt, load_rt;
  logic       held_load, hazard, accept;

  assign in_rs   = in_data[INST_LO+25 -: 5];
  assign in_rt   = in_data[INST_LO+20 -: 5];
  assign load_rt = out_data[INST_LO+20 -: 5];

  // Held bundle is a load writing rt; rs and rt of the incoming bundle are both
  // compared, regardless of whether it actually reads them.
  assign held_load = out_valid & out_data[MEM_RD] & out_data[WR_RT] & (load_rt != 5'd0);
  assign hazard    = held_load & in_valid & ((in_rs == load_rt) | (in_rt == load_rt));

  assign in_ready  = flush | ((~out_valid | out_ready) & ~hazard);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      // Flush drops the incoming bundle even though in_ready is high.
      if (flush)
        out_valid <= 1'b0;
      else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (out_valid & out_ready)
        out_valid <= 1'b0;

      if (in_valid & ~in_ready & ~flush)
        stall_cnt <= stall_cnt + 1'b1;
      if (hazard & out_ready & ~flush)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
